divider_sequencer: RTL and testbench
====================================

Name: divider_sequencer

Overview:
Issue/collect front end sitting directly upstream of divider_32 in the ALU.
- Accepts signed 32-bit divide requests over a valid/ready handshake and launches divider_32 (pulses its rst, holds its ena).
- Waits for dne, then presents quotient and remainder downstream with valid/ready.
- Resolves divide-by-zero and signed overflow locally, and aborts with an error flag if the divider never completes.

Parameters:
TIMEOUT, 40, maximum BUSY cycles to wait for div_dne before aborting (32 iterations plus margin); legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request operands valid
req_ready  output  1  sequencer can accept a request
req_a  input  32  signed dividend
req_b  input  32  signed divisor
res_valid  output  1  result valid
res_ready  input  1  consumer accepts result
res_q  output  32  signed quotient
res_r  output  32  signed remainder
res_dz  output  1  divide-by-zero flag
res_ovf  output  1  signed-overflow flag
res_err  output  1  divider timeout flag
div_a  output  32  dividend to divider_32 (a)
div_b  output  32  divisor to divider_32 (b)
div_start  output  1  to divider_32 rst; one-cycle load pulse
div_ena  output  1  to divider_32 ena
div_q  input  32  divider_32 q
div_r  input  32  divider_32 r
div_dne  input  1  divider_32 dne

Behaviour:
- Async reset: state=IDLE; req_ready=1; res_valid=0; res_q, res_r, div_a, div_b=0; res_dz, res_ovf, res_err=0; div_start=0; div_ena=0; timeout counter=0.
- Reset mid-operation discards the in-flight divide and the pending result. The divider is re-loaded on the next request.

FSM states and transitions:
- IDLE: req_ready=1. On req_valid, register req_a/req_b into div_a/div_b and clear all flags.
  - req_b==0: go to DONE with res_q=32'hFFFFFFFF, res_r=req_a, res_dz=1.
  - req_a==32'h80000000 and req_b==32'hFFFFFFFF: go to DONE with res_q=32'h80000000, res_r=0, res_ovf=1.
  - Otherwise: go to START.
- START: div_start=1, div_ena=1 for exactly one cycle; counter cleared; go to BUSY.
- BUSY: div_start=0, div_ena=1; counter increments each cycle.
  - div_dne=1: capture div_q/div_r into res_q/res_r; go to DONE.
  - Counter reaches TIMEOUT with no dne: res_q=0, res_r=0, res_err=1; go to DONE.
  - dne takes priority over timeout in the same cycle.
- DONE: res_valid=1, results and flags held stable, div_ena=0. On res_ready, go to IDLE (res_valid drops the next cycle).

Handshake and timing rules:
- req_ready=1 only in IDLE.
- A request arriving together with res_ready in DONE is not accepted until IDLE, so throughput is at most one result per (latency+1) cycles.
- div_dne is ignored outside BUSY; a stale dne from the previous operation must never be captured in START.
- Latency from request accept to res_valid:
  - Bypass cases (dz, ovf): 1 cycle.
  - Normal: 2 + N cycles, where N is the number of BUSY cycles until dne.
- The divider returns truncating signed results: quotient rounds toward zero, remainder takes the sign of the dividend. The sequencer passes them through unmodified.
- div_a and div_b remain stable from accept until the next accept.

Test Plan:
- a=100, b=7 -> res_q=14, res_r=2, all flags 0; exactly one div_start pulse seen.
- a=-100, b=7 -> res_q=-14 (32'hFFFFFFF2), res_r=-2; a=100, b=-7 -> res_q=-14, res_r=2.
- a=5, b=0 -> res_valid 1 cycle after accept, res_q=32'hFFFFFFFF, res_r=5, res_dz=1; div_start never asserted.
- a=32'h80000000, b=-1 -> res_q=32'h80000000, res_r=0, res_ovf=1, no div_start; then a=32'h80000000, b=1 -> res_q=32'h80000000, res_r=0 via the divider.
- Backpressure: res_ready held low 10 cycles after res_valid -> res_valid, res_q and res_r stable, req_ready=0. A req_valid pulse during DONE is not accepted.
- Divider stub with dne tied 0 -> res_err=1 exactly TIMEOUT BUSY cycles after START, res_q=res_r=0.
- Assert rst mid-BUSY -> all outputs return to reset values immediately; the next request completes correctly.

Source files
------------

// File: rtl/divider_sequencer.sv
// rtl/divider_sequencer.sv - issue/collect front end for divider_32
// Bypasses divide-by-zero and INT_MIN/-1, otherwise launches the divider and waits for dne or timeout.
module divider_sequencer #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_q,
  output logic [31:0] res_r,
  output logic        res_dz,
  output logic        res_ovf,
  output logic        res_err,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  output logic        div_ena,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_dne
);

  localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;
  logic        w_dz;
  logic        w_ovf;
  logic [31:0] r_div_a;
  logic [31:0] r_div_b;
  logic [31:0] r_res_q;
  logic [31:0] r_res_r;
  logic        r_dz;
  logic        r_ovf;
  logic        r_err;

  assign w_dz      = (req_b == 32'd0);
  assign w_ovf     = (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
  assign w_cnt_inc = r_cnt + 8'd1;
  // Fires on the TIMEOUT-th BUSY cycle without dne.
  assign w_timeout = (w_cnt_inc == L_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next = (w_dz || w_ovf) ? S_DONE : S_START;
        end
      end
      S_START: w_next = S_BUSY;
      S_BUSY: begin
        if (div_dne || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    res_valid = 1'b0;
    div_start = 1'b0;
    div_ena   = 1'b0;
    case (r_state)
      S_IDLE:  req_ready = 1'b1;
      S_START: begin
        div_start = 1'b1;
        div_ena   = 1'b1;
      end
      S_BUSY:  div_ena   = 1'b1;
      S_DONE:  res_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_a <= 32'd0;
      r_div_b <= 32'd0;
      r_res_q <= 32'd0;
      r_res_r <= 32'd0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_div_a <= req_a;
            r_div_b <= req_b;
            r_dz    <= w_dz;
            r_ovf   <= w_ovf && !w_dz;
            r_err   <= 1'b0;
            if (w_dz) begin
              r_res_q <= 32'hFFFF_FFFF;
              r_res_r <= req_a;
            end else if (w_ovf) begin
              r_res_q <= 32'h8000_0000;
              r_res_r <= 32'd0;
            end
          end
        end
        S_START: r_cnt <= 8'd0;
        S_BUSY: begin
          r_cnt <= w_cnt_inc;
          if (div_dne) begin
            r_res_q <= div_q;
            r_res_r <= div_r;
          end else if (w_timeout) begin
            r_res_q <= 32'd0;
            r_res_r <= 32'd0;
            r_err   <= 1'b1;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign div_a   = r_div_a;
  assign div_b   = r_div_b;
  assign res_q   = r_res_q;
  assign res_r   = r_res_r;
  assign res_dz  = r_dz;
  assign res_ovf = r_ovf;
  assign res_err = r_err;

endmodule

// File: tb/tb_divider_sequencer.sv
// tb/tb_divider_sequencer.sv - table-driven scoreboard bench for divider_sequencer
// A behavioural divider_32 stub answers after a fixed delay, or never when hang is set.
module tb_divider_sequencer;

  localparam int TIMEOUT  = 40;
  localparam int STUB_LAT = 33;
  localparam int NORM_LAT = STUB_LAT + 3;
  localparam int TO_LAT   = TIMEOUT + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_q;
  logic [31:0] res_r;
  logic        res_dz;
  logic        res_ovf;
  logic        res_err;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_start;
  logic        div_ena;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_dne;

  always #5 clk = ~clk;

  divider_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_r(res_r),
    .res_dz(res_dz), .res_ovf(res_ovf), .res_err(res_err),
    .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_ena(div_ena),
    .div_q(div_q), .div_r(div_r), .div_dne(div_dne)
  );

  logic [31:0] s_q;
  logic [31:0] s_r;
  logic        s_dne;
  int          s_cnt;
  bit          stub_hang = 1'b0;
  int          n_start = 0;

  // dne stays high after completion until the next load, like the real divider.
  always @(posedge clk) begin
    if (rst) begin
      s_q   <= 32'd0;
      s_r   <= 32'd0;
      s_dne <= 1'b0;
      s_cnt <= 0;
    end else if (div_start) begin
      s_cnt <= 0;
      s_dne <= 1'b0;
      if (div_b == 32'd0) begin
        s_q <= 32'd0;
        s_r <= 32'd0;
      end else if (div_a == 32'h8000_0000 && div_b == 32'hFFFF_FFFF) begin
        s_q <= 32'h8000_0000;
        s_r <= 32'd0;
      end else begin
        s_q <= $signed(div_a) / $signed(div_b);
        s_r <= $signed(div_a) % $signed(div_b);
      end
    end else if (div_ena && !s_dne && !stub_hang) begin
      s_cnt <= s_cnt + 1;
      if (s_cnt + 1 == STUB_LAT) s_dne <= 1'b1;
    end
  end

  always @(posedge clk) if (div_start) n_start <= n_start + 1;

  assign div_q   = s_q;
  assign div_r   = s_r;
  assign div_dne = s_dne;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          hang;
    logic [31:0] q;
    logic [31:0] r;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [2:0]  flags;
    int          lat;
    int          starts;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v, output int snap, output bit ok);
    int w;
    stub_hang = v.hang;
    @(negedge clk);
    req_a = v.a;
    req_b = v.b;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
    ok = req_ready;
    if (ok) sb.push_back('{v.q, v.r, v.flags, v.lat, (v.flags[2] | v.flags[1]) ? 0 : 1});
    snap = n_start;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input int snap, input int hold, input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    if (!res_valid || sb.size() == 0) return;
    e = sb.pop_front();
    if (e.lat != 0) check({tag, "_latency"}, lat, e.lat);
    check({tag, "_starts"}, n_start - snap, e.starts);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
      check({tag, "_hold_q"}, res_q, e.q);
      check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
      if (i == 3) begin
        req_a = 32'd9;
        req_b = 32'd3;
        req_valid = 1'b1;
      end
      if (i == 4) req_valid = 1'b0;
      @(negedge clk);
    end
    check({tag, "_q"}, res_q, e.q);
    check({tag, "_r"}, res_r, e.r);
    check({tag, "_flags"}, {29'd0, res_dz, res_ovf, res_err}, {29'd0, e.flags});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_ctl"}, {28'd0, res_valid, div_start, div_ena, 1'b0}, 32'd0);
    check({tag, "_res_q"}, res_q, 32'd0);
    check({tag, "_res_r"}, res_r, 32'd0);
    check({tag, "_div_a"}, div_a, 32'd0);
    check({tag, "_div_b"}, div_b, 32'd0);
    check({tag, "_flags"}, {29'd0, res_dz, res_ovf, res_err}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int snap;
    bit ok;
    vecs[0]  = '{32'd100,         32'd7,           1'b0, 32'd14,          32'd2,           3'b000, NORM_LAT};
    vecs[1]  = '{-32'sd100,       32'd7,           1'b0, 32'hFFFF_FFF2,   32'hFFFF_FFFE,   3'b000, NORM_LAT};
    vecs[2]  = '{32'd100,         -32'sd7,         1'b0, 32'hFFFF_FFF2,   32'd2,           3'b000, NORM_LAT};
    vecs[3]  = '{32'd5,           32'd0,           1'b0, 32'hFFFF_FFFF,   32'd5,           3'b100, 1};
    vecs[4]  = '{32'h8000_0000,   32'hFFFF_FFFF,   1'b0, 32'h8000_0000,   32'd0,           3'b010, 1};
    vecs[5]  = '{32'h8000_0000,   32'd1,           1'b0, 32'h8000_0000,   32'd0,           3'b000, NORM_LAT};
    vecs[6]  = '{32'd7,           32'd100,         1'b0, 32'd0,           32'd7,           3'b000, NORM_LAT};
    vecs[7]  = '{-32'sd7,         -32'sd2,         1'b0, 32'd3,           32'hFFFF_FFFF,   3'b000, NORM_LAT};
    vecs[8]  = '{32'hFFFF_FFFF,   32'd0,           1'b0, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   3'b100, 1};
    vecs[9]  = '{32'd1234,        32'd5,           1'b1, 32'd0,           32'd0,           3'b001, TO_LAT};
    vecs[10] = '{32'h8000_0000,   32'd2,           1'b0, 32'hC000_0000,   32'd0,           3'b000, NORM_LAT};
    vecs[11] = '{32'd0,           32'd0,           1'b0, 32'hFFFF_FFFF,   32'd0,           3'b100, 1};

    rst = 1'b1;
    req_valid = 1'b0;
    req_a = 32'd0;
    req_b = 32'd0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i], snap, ok);
      if (ok) collect(snap, 0, $sformatf("vec%0d", i));
    end

    issue(vecs[0], snap, ok);
    if (ok) collect(snap, 10, "backpressure");
    repeat (3) @(negedge clk);
    check("no_stray_accept", {31'd0, res_valid}, 32'd0);

    issue(vecs[9], snap, ok);
    repeat (5) @(negedge clk);
    check("mid_busy_ena", {31'd0, div_ena}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    sb.delete();

    issue(vecs[1], snap, ok);
    if (ok) collect(snap, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
